mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Load/store stage between the datapath and the synchronous data RAM; single outstanding request.
// - Executes STR with store data from the regfile str port, and LDR via the RAM.
// - Returns LDR results to the regfile's second write port (w_data_ldr/w_addr_ldr/w_en_ldr).
// - Exports the pending load destination so decode can stall on read-after-load hazards.
// PARAMETERS
// ADDR_W   7   RAM word-address width; matches the PC width
// DATA_W   32  data word width
// RAM_LAT  1   RAM read latency in cycles; legal range 1..3
// PORTS
// clk            in   1       clock; all state updates on posedge
// rst            in   1       asynchronous active-high reset
// req_valid      in   1       request present
// req_ready      out  1       unit can accept; high only in IDLE
// req_is_load    in   1       1 = LDR, 0 = STR
// req_addr       in   32      byte address from the datapath ALU
// req_rd         in   4       LDR destination register
// req_str_data   in   DATA_W  STR data, from regfile str_data
// mem_addr       out  ADDR_W  RAM word address
// mem_wdata      out  DATA_W  RAM write data
// mem_wren       out  1       RAM write strobe
// mem_rdata      in   DATA_W  RAM read data, valid RAM_LAT cycles after mem_addr
// w_data_ldr     out  DATA_W  load result to regfile
// w_addr_ldr     out  4       load destination to regfile
// w_en_ldr       out  1       load write enable, one-cycle pulse
// pend_valid     out  1       a load is in flight
// pend_rd        out  4       destination register of the in-flight load
// err_addr       out  1       one-cycle pulse: rejected request
// BEHAVIOUR
// - Reset (async, any state): state IDLE, all outputs 0 except req_ready=1; in-flight load is discarded, no regfile write.
// - Accept: handshake at posedge with req_valid && req_ready. The unit registers addr, rd, data and kind.
// - Word address is req_addr[ADDR_W+1:2].
// - Error: req_addr[1:0] != 0, or any bit of req_addr[31:ADDR_W+2] set. The request is still accepted.
//   err_addr pulses in the next cycle; no RAM access, no regfile write; state stays IDLE.
// - FSM: IDLE -> STORE -> IDLE, and IDLE -> READ -> WB -> IDLE.
// - STORE: accepted in cycle T.
//   - T+1: mem_wren=1, mem_addr/mem_wdata valid, req_ready=0.
//   - T+2: back in IDLE, ready=1. Back-to-back stores run at one per 2 cycles.
// - READ: accepted in cycle T.
//   - mem_addr is held from T+1 to T+RAM_LAT, with mem_wren=0.
//   - An inline counter counts RAM_LAT cycles.
//   - mem_rdata is captured at the end of T+RAM_LAT.
// - WB, cycle T+RAM_LAT+1: w_en_ldr=1 with captured data and rd; ready returns at T+RAM_LAT+2.
// - Load to R15: the full sequence runs, but w_en_ldr stays 0; PC loads are not supported.
// - pend_valid=1 and pend_rd=rd from T+1 through the WB cycle inclusive; otherwise pend_valid=0.
//   If rd==15, pend_valid is still asserted.
// - mem_wren is never high outside STORE; w_en_ldr is never high outside WB.
// - req_valid while not ready is ignored (no queueing). The requester holds the request until accepted.
// - mem_addr and mem_wdata hold their last value when idle.
// STRUCTURE
// - Shared package mau_pkg holds:
//   - typedef enum logic [1:0] {IDLE, STORE, READ, WB} mau_state_t
//   - localparam PC_IDX = 4'd15
//   - default ADDR_W/DATA_W constants, shared with the regfile and fetch
// - No sub-module; the latency counter is a 2-bit inline register.
// TESTING
// - STR, addr=0x10, data=0xDEADBEEF: at T+1 mem_wren=1, mem_addr=4, mem_wdata=0xDEADBEEF; ready=1 at T+2.
// - LDR r3, addr=0x10, RAM_LAT=1, RAM[4]=0xDEADBEEF: at T+2 w_en_ldr=1, w_addr_ldr=3, w_data_ldr=0xDEADBEEF.
//   pend_valid=1 at T+1..T+2.
// - Repeat the LDR test with RAM_LAT=3: write-back at T+4, ready at T+5, mem_addr stable T+1..T+3.
// - Error cases, each giving an err_addr pulse at T+1 with mem_wren=0, w_en_ldr=0, ready=1:
//   - addr=0x12 (misaligned)
//   - addr=0x200 with ADDR_W=7 (out of range)
// - LDR r15: full timing, w_en_ldr=0 throughout, pend_valid=1 until WB.
// - Assert rst during READ (T+1): outputs 0 immediately, no w_en_ldr pulse, next request after release behaves normally.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit, regfile and fetch stages.
package mau_pkg;

  // Load/store sequencer states
  typedef enum logic [1:0] {IDLE, STORE, READ, WB} mau_state_t;

  // Register index of the program counter; loads into it are suppressed
  localparam logic [3:0] PC_IDX = 4'd15;

  // Default word-address and data widths used across the core
  localparam int MAU_ADDR_W = 7;
  localparam int MAU_DATA_W = 32;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store stage between the datapath and the synchronous data RAM.
// One request at a time: stores take two cycles, loads take RAM_LAT+2 cycles.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = MAU_ADDR_W,
  parameter int DATA_W  = MAU_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_rd,
  input  logic [DATA_W-1:0] req_str_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic              pend_valid,
  output logic [3:0]        pend_rd,
  output logic              err_addr
);

  localparam logic [1:0] LAT_C = 2'(RAM_LAT);

  mau_state_t  state;
  logic [1:0]  lat_cnt;
  logic        accept;
  logic        bad_addr;
  logic [ADDR_W-1:0] word_addr;

  // Misaligned byte address, or address beyond the RAM's word range
  function automatic logic addr_is_bad(input logic [31:0] a);
    return (|a[1:0]) || (|a[31:ADDR_W+2]);
  endfunction

  assign accept    = req_valid && req_ready;
  assign bad_addr  = addr_is_bad(req_addr);
  assign word_addr = req_addr[ADDR_W+1:2];

  // Sequencer with registered RAM, regfile and hazard outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      req_ready  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      w_data_ldr <= '0;
      w_addr_ldr <= 4'd0;
      w_en_ldr   <= 1'b0;
      pend_valid <= 1'b0;
      pend_rd    <= 4'd0;
      err_addr   <= 1'b0;
    end else begin
      err_addr <= 1'b0;
      mem_wren <= 1'b0;
      w_en_ldr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad_addr) begin
              // Rejected: consume the request, flag it, stay ready
              err_addr <= 1'b1;
            end else if (req_is_load) begin
              state      <= READ;
              mem_addr   <= word_addr;
              lat_cnt    <= 2'd1;
              pend_valid <= 1'b1;
              pend_rd    <= req_rd;
              req_ready  <= 1'b0;
            end else begin
              state     <= STORE;
              mem_addr  <= word_addr;
              mem_wdata <= req_str_data;
              mem_wren  <= 1'b1;
              req_ready <= 1'b0;
            end
          end
        end
        STORE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        READ: begin
          // Address is held; capture read data on the last latency cycle
          if (lat_cnt == LAT_C) begin
            state      <= WB;
            w_data_ldr <= mem_rdata;
            w_addr_ldr <= pend_rd;
            w_en_ldr   <= (pend_rd != PC_IDX);
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        WB: begin
          state      <= IDLE;
          pend_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (RAM_LAT=1 and RAM_LAT=3) share the
// request bus; a per-transaction timeline model gives expected outputs.
module tb_mem_access_unit;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sel;
  logic          req_valid;
  logic          req_is_load;
  logic [31:0]   req_addr;
  logic [3:0]    req_rd;
  logic [DW-1:0] req_str_data;

  logic          vld   [2];
  logic          rdy   [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdata[2];
  logic          mwren [2];
  logic [DW-1:0] mrdata[2];
  logic [DW-1:0] wdata [2];
  logic [3:0]    waddr [2];
  logic          wen   [2];
  logic          pend  [2];
  logic [3:0]    prd   [2];
  logic          err   [2];

  assign vld[0] = req_valid && !sel;
  assign vld[1] = req_valid && sel;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(vld[0]), .req_ready(rdy[0]), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_rd(req_rd), .req_str_data(req_str_data),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_wren(mwren[0]),
    .mem_rdata(mrdata[0]),
    .w_data_ldr(wdata[0]), .w_addr_ldr(waddr[0]), .w_en_ldr(wen[0]),
    .pend_valid(pend[0]), .pend_rd(prd[0]), .err_addr(err[0])
  );

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(vld[1]), .req_ready(rdy[1]), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_rd(req_rd), .req_str_data(req_str_data),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_wren(mwren[1]),
    .mem_rdata(mrdata[1]),
    .w_data_ldr(wdata[1]), .w_addr_ldr(waddr[1]), .w_en_ldr(wen[1]),
    .pend_valid(pend[1]), .pend_rd(prd[1]), .err_addr(err[1])
  );

  // Environment RAMs (written by the DUTs) and model RAMs (written by the bench)
  logic [DW-1:0] ram_env[2][128];
  logic [DW-1:0] ram_mod[2][128];
  logic [AW-1:0] hist1[2];

  // RAM write port and address history for the three-cycle-latency RAM
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 128; j++)
          ram_env[i][j] <= ram_mod[i][j];
    end else begin
      for (int i = 0; i < 2; i++)
        if (mwren[i]) ram_env[i][maddr[i]] <= mwdata[i];
    end
    hist1[0] <= maddr[1];
    hist1[1] <= hist1[0];
  end

  // Read data reflects the address presented RAM_LAT-1 cycles earlier
  assign mrdata[0] = ram_env[0][maddr[0]];
  assign mrdata[1] = ram_env[1][hist1[1]];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (dut%0d t=%0t): got 0x%0h expected 0x%0h", name, sel, $time, act, exp);
    end
  endtask

  // Issue one request on instance s and check every cycle until ready returns
  task automatic do_req(input bit s, input bit ld, input logic [31:0] a, input logic [3:0] rd,
                        input logic [31:0] d, input bit eerr, input logic [6:0] eword,
                        input bit noise);
    int n, lat, to;
    bit e_rdy, e_err, e_wren, e_pend, e_wen;
    lat = s ? 3 : 1;
    sel = s;
    to = 0;
    while (!rdy[s] && to < 20) begin
      @(negedge clk);
      to++;
    end
    if (!rdy[s]) begin
      chk("ready_timeout", 32'(rdy[s]), 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_addr     = a;
    req_rd       = rd;
    req_str_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = eerr ? 1 : (ld ? lat + 2 : 2);
    if (!eerr && !ld) ram_mod[s][eword] = d;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e_rdy  = (k == n);
      e_err  = eerr && (k == 1);
      e_wren = !eerr && !ld && (k == 1);
      e_pend = !eerr && ld && (k <= lat + 1);
      e_wen  = !eerr && ld && (k == lat + 1) && (rd != 4'd15);
      chk("req_ready", 32'(rdy[s]), 32'(e_rdy));
      chk("err_addr", 32'(err[s]), 32'(e_err));
      chk("mem_wren", 32'(mwren[s]), 32'(e_wren));
      chk("pend_valid", 32'(pend[s]), 32'(e_pend));
      chk("w_en_ldr", 32'(wen[s]), 32'(e_wen));
      if (!eerr) chk("mem_addr", 32'(maddr[s]), 32'(eword));
      if (!eerr && !ld) chk("mem_wdata", mwdata[s], d);
      if (e_pend) chk("pend_rd", 32'(prd[s]), 32'(rd));
      if (e_wen) begin
        chk("w_addr_ldr", 32'(waddr[s]), 32'(rd));
        chk("w_data_ldr", wdata[s], ram_mod[s][eword]);
      end
      // Unaccepted traffic while busy must be ignored
      req_valid = noise && (k + 1 < n);
      if (req_valid) begin
        req_addr     = $urandom;
        req_is_load  = 1'($urandom_range(0, 1));
        req_str_data = $urandom;
        req_rd       = 4'($urandom_range(0, 15));
      end
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    bit          s;
    bit          ld;
    logic [31:0] a;
    logic [3:0]  rd;
    logic [31:0] d;
    bit          eerr;
    logic [6:0]  eword;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit          s, ld, eerr;
    logic [31:0] a;
    logic [6:0]  w;

    rst = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_is_load = 1'b0;
    req_addr = '0;
    req_rd = '0;
    req_str_data = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 128; j++)
        ram_mod[i][j] = $urandom;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'd0,  32'hDEAD_BEEF, 1'b0, 7'd4};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0010, 4'd3,  32'h0,         1'b0, 7'd4};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0010, 4'd0,  32'hDEAD_BEEF, 1'b0, 7'd4};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0010, 4'd3,  32'h0,         1'b0, 7'd4};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0012, 4'd0,  32'h1111_2222, 1'b1, 7'd0};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0200, 4'd2,  32'h0,         1'b1, 7'd0};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_01FC, 4'd15, 32'h0,         1'b0, 7'h7F};
    tbl[7] = '{1'b0, 1'b0, 32'h0000_01FC, 4'd0,  32'h1234_5678, 1'b0, 7'h7F};
    tbl[8] = '{1'b1, 1'b1, 32'h8000_0010, 4'd7,  32'h0,         1'b1, 7'd0};
    tbl[9] = '{1'b1, 1'b0, 32'h0000_0000, 4'd0,  32'hA5A5_A5A5, 1'b0, 7'd0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      chk("rst_ready", 32'(rdy[i]), 32'd1);
      chk("rst_wren", 32'(mwren[i]), 32'd0);
      chk("rst_wen", 32'(wen[i]), 32'd0);
      chk("rst_pend", 32'(pend[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_maddr", 32'(maddr[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_req(tbl[i].s, tbl[i].ld, tbl[i].a, tbl[i].rd, tbl[i].d, tbl[i].eerr, tbl[i].eword, 1'(i % 2));

    // Reset in the first READ cycle of the three-cycle-latency instance
    sel = 1'b1;
    req_valid = 1'b1;
    req_is_load = 1'b1;
    req_addr = 32'h0000_0020;
    req_rd = 4'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rr_pend_before", 32'(pend[1]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rr_ready", 32'(rdy[1]), 32'd1);
    chk("rr_pend", 32'(pend[1]), 32'd0);
    chk("rr_pend_rd", 32'(prd[1]), 32'd0);
    chk("rr_wen", 32'(wen[1]), 32'd0);
    chk("rr_wren", 32'(mwren[1]), 32'd0);
    chk("rr_maddr", 32'(maddr[1]), 32'd0);
    chk("rr_wdata", wdata[1], 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_hold_wen", 32'(wen[1]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_after_wen", 32'(wen[1]), 32'd0);
    end
    do_req(1'b1, 1'b1, 32'h0000_0020, 4'd5, 32'h0, 1'b0, 7'd8, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 80; i++) begin
      s  = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 127)) * 4;
      eerr = (a[1:0] != 2'b00) || (a[31:9] != 23'd0);
      w = a[8:2];
      do_req(s, ld, a, 4'($urandom_range(0, 15)), $urandom, eerr, w, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
